mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: ack watchdog limit; used only when MEM_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mem_read, mem_write  input  1 each  pipeline access strobes (MEM stage).
REQ-005 loadtype  input  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW.
REQ-006 storetype  input  2  0 SB, 1 SH, 2 SW; 3 reserved.
REQ-007 addr  input  32  byte address; wdata  input  32  store data, right-justified.
REQ-008 stall  output  1  freeze pipeline while access is outstanding.
REQ-009 data_valid  output  1  one-cycle strobe: rdata_word/addr_low/loadtype_out valid.
REQ-010 rdata_word  output  32  raw memory word; addr_low  output  2; loadtype_out  output  3 (feed the load extractor).
REQ-011 addr_err  output  1  misalignment pulse; bus_err  output  1  timeout pulse.
REQ-012 mem_req, mem_we  output  1; mem_be  output  4; mem_addr  output  32 (bits[1:0]=0); mem_wdata  output  32.
REQ-013 mem_ack  input  1; mem_rdata  input  32.

Function
REQ-014 FSM states IDLE, REQ, DONE; IDLE->REQ on valid access, REQ->DONE on mem_ack (or timeout), DONE->IDLE unconditionally.
REQ-015 Valid access: (mem_read|mem_write) and aligned; mem_write has priority when both asserted (store issued, no read).
REQ-016 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; storetype 3 also errors; -> addr_err=1 same cycle (combinational), no mem_req, stall=0, state stays IDLE.
REQ-017 stall = (IDLE and valid access) or REQ; stall=0 in DONE.
REQ-018 In IDLE on valid access, register mem_addr={addr[31:2],2'b00}, mem_we, mem_be, mem_wdata, addr_low, loadtype_out; mem_req=1 from next cycle.
REQ-019 mem_req, mem_addr, mem_be, mem_we, mem_wdata held stable in REQ until the cycle mem_ack=1 is sampled.
REQ-020 SB: mem_wdata=wdata[7:0] replicated x4, mem_be=4'b0001<<addr[1:0]; SH: wdata[15:0] replicated x2, mem_be=addr[1]?4'b1100:4'b0011; SW: wdata, 4'b1111.
REQ-021 Loads: mem_be=4'b1111, mem_we=0.
REQ-022 On ack in REQ: rdata_word<=mem_rdata for reads (unchanged for writes), mem_req<=0; DONE asserts data_valid=1 for exactly one cycle (reads only).
REQ-023 Minimum latency: access at cycle 0, mem_req cycle 1, ack cycle 1 -> DONE/stall low cycle 2.
REQ-024 mem_ack in IDLE or DONE ignored.

Reset
REQ-025 rst asserted: state=IDLE; mem_req, mem_we, data_valid, bus_err=0; mem_be, mem_addr, mem_wdata, rdata_word=0; addr_low=0, loadtype_out=0.
REQ-026 Reset mid-REQ drops mem_req immediately; a later ack is ignored.

Configuration
REQ-027 MEM_TIMEOUT_EN defined: counter in REQ; ack absent for TIMEOUT_CYCLES cycles -> drop mem_req, bus_err=1 one cycle, rdata_word=0, go DONE.
REQ-028 MEM_TIMEOUT_EN undefined: no counter, no bus_err logic (tied 0), REQ waits indefinitely.

Structure
REQ-029 Package mips_mem_pkg: loadtype/storetype encodings, FSM state encoding.
REQ-030 Sub-module store_align: combinational mem_be/mem_wdata lane steering from storetype, addr[1:0], wdata.

Verification
REQ-031 LW addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, data_valid cycle 2, rdata_word 0xDEADBEEF, loadtype_out 4.
REQ-032 SB addr 0x203, wdata 0x000000A5 -> be 1000, mem_wdata 0xA5A5A5A5, mem_we 1, no data_valid.
REQ-033 LH addr 0x101 -> addr_err 1, stall 0, mem_req never asserted.
REQ-034 LBU addr 0x302, ack after 5 wait cycles -> stall held 6 cycles, request fields stable, addr_low 2.
REQ-035 rst pulsed during REQ, ack 2 cycles later -> mem_req 0 immediately, state IDLE, no data_valid.
REQ-036 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err pulse after 4 REQ cycles, rdata_word 0, stall released.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage access unit: load/store types, FSM states
// and the alignment rule used to reject misaligned accesses.
package mips_mem_pkg;

  localparam logic [2:0] LT_LB  = 3'd0;
  localparam logic [2:0] LT_LBU = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LHU = 3'd3;
  localparam logic [2:0] LT_LW  = 3'd4;

  localparam logic [1:0] ST_SB   = 2'd0;
  localparam logic [1:0] ST_SH   = 2'd1;
  localparam logic [1:0] ST_SW   = 2'd2;
  localparam logic [1:0] ST_RSVD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Stores are judged by storetype (reserved encoding always faults); loads by loadtype.
  function automatic logic misaligned(input logic       is_store,
                                      input logic [2:0] lt,
                                      input logic [1:0] st,
                                      input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    if (is_store) begin
      case (st)
        ST_SB:   bad = 1'b0;
        ST_SH:   bad = a[0];
        ST_SW:   bad = |a;
        default: bad = 1'b1;
      endcase
    end else begin
      case (lt)
        LT_LH, LT_LHU: bad = a[0];
        LT_LW:         bad = |a;
        default:       bad = 1'b0;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/store_align.sv
// Store lane steering: replicates store data across the word and selects the
// byte enables for the addressed lane(s).
module store_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_storetype,
  input  logic [1:0]  i_addr_low,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata
);

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    case (i_storetype)
      ST_SB: begin
        o_be    = 4'b0001 << i_addr_low;
        o_wdata = {4{i_wdata[7:0]}};
      end
      ST_SH: begin
        o_be    = i_addr_low[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      ST_SW: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit: IDLE/REQ/DONE handshake with a word-addressed bus.
// Define MEM_TIMEOUT_EN to enable the ack watchdog (TIMEOUT_CYCLES) and bus_err.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  loadtype,
  input  logic [1:0]  storetype,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        data_valid,
  output logic [31:0] rdata_word,
  output logic [1:0]  addr_low,
  output logic [2:0]  loadtype_out,
  output logic        addr_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      r_state;
  state_t      w_next;
  logic        w_access;
  logic        w_misalign;
  logic        w_valid;
  logic        w_timeout;
  logic        w_done;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata_word;
  logic [1:0]  r_addr_low;
  logic [2:0]  r_loadtype;
  logic        r_data_valid;
  logic        r_bus_err;

  store_align u_store_align (
    .i_storetype (storetype),
    .i_addr_low  (addr[1:0]),
    .i_wdata     (wdata),
    .o_be        (w_st_be),
    .o_wdata     (w_st_wdata)
  );

  assign w_access   = mem_read | mem_write;
  assign w_misalign = misaligned(mem_write, loadtype, storetype, addr[1:0]);
  assign w_valid    = (r_state == S_IDLE) && w_access && !w_misalign;
  assign addr_err   = (r_state == S_IDLE) && w_access && w_misalign;
  assign stall      = w_valid || (r_state == S_REQ);
  assign w_done     = (r_state == S_REQ) && (mem_ack || w_timeout);

`ifdef MEM_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;

  // Counts REQ cycles without ack; cleared whenever the FSM is outside REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_tmo_cnt <= 32'd0;
    else if (r_state != S_REQ)
      r_tmo_cnt <= 32'd0;
    else if (!mem_ack)
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
  end

  assign w_timeout = (r_state == S_REQ) && !mem_ack && (r_tmo_cnt == TIMEOUT_CYCLES - 1);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_valid) w_next = S_REQ;
      S_REQ:   if (w_done) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields are captured once in IDLE and held untouched through REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'b0000;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_rdata_word <= 32'h0;
      r_addr_low   <= 2'b00;
      r_loadtype   <= 3'd0;
      r_data_valid <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= mem_write;
            r_mem_be    <= mem_write ? w_st_be : 4'b1111;
            r_mem_addr  <= {addr[31:2], 2'b00};
            r_mem_wdata <= mem_write ? w_st_wdata : 32'h0;
            r_addr_low  <= addr[1:0];
            r_loadtype  <= loadtype;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) begin
              r_rdata_word <= mem_rdata;
              r_data_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            r_mem_req    <= 1'b0;
            r_bus_err    <= 1'b1;
            r_rdata_word <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_be       = r_mem_be;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign rdata_word   = r_rdata_word;
  assign addr_low     = r_addr_low;
  assign loadtype_out = r_loadtype;
  assign data_valid   = r_data_valid;
  assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus read-data scoreboard,
// with hand-written reset, ack-in-idle and ack-watchdog sequences.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int LONG_DLY = 3;
`else
  localparam int LONG_DLY = 5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  loadtype;
  logic [1:0]  storetype;
  logic [31:0] addr, wdata;
  logic        stall, data_valid, addr_err, bus_err;
  logic [31:0] rdata_word;
  logic [1:0]  addr_low;
  logic [2:0]  loadtype_out;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .loadtype(loadtype), .storetype(storetype), .addr(addr), .wdata(wdata),
    .stall(stall), .data_valid(data_valid), .rdata_word(rdata_word),
    .addr_low(addr_low), .loadtype_out(loadtype_out), .addr_err(addr_err),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  lt;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  alow;
    logic [2:0]  lt;
  } exp_t;

  vec_t vecs[14];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    loadtype  = 3'd0;
    storetype = 2'd0;
    addr      = 32'h0;
    wdata     = 32'h0;
  endtask

  task automatic drive(input vec_t v);
    mem_read  = v.rd;
    mem_write = v.wr;
    loadtype  = v.lt;
    storetype = v.st;
    addr      = v.addr;
    wdata     = v.wdata;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          n_stall;
    logic [31:0] exp_addr;
    exp_t        e;
    drive(v);
    #1;
    chk($sformatf("v%0d addr_err", idx), addr_err, v.err);
    chk($sformatf("v%0d stall_idle", idx), stall, !v.err);
    if (v.err) begin
      tick();
      chk($sformatf("v%0d no_req", idx), mem_req, 1'b0);
      chk($sformatf("v%0d err_stall", idx), stall, 1'b0);
      idle_inputs();
      return;
    end
    if (v.rd && !v.wr) sb_q.push_back('{v.rdata, v.addr[1:0], v.lt});
    exp_addr = {v.addr[31:2], 2'b00};
    tick();
    n_stall = 0;
    for (int w = 0; w <= v.dly; w++) begin
      if (w == v.dly) begin
        mem_ack   = 1'b1;
        mem_rdata = v.rdata;
      end else begin
        mem_rdata = $urandom;
      end
      #1;
      if (stall) n_stall++;
      chk($sformatf("v%0d mem_req", idx), mem_req, 1'b1);
      chk($sformatf("v%0d mem_addr", idx), mem_addr, exp_addr);
      chk($sformatf("v%0d mem_be", idx), mem_be, v.be);
      chk($sformatf("v%0d mem_we", idx), mem_we, v.wr);
      if (v.wr) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.mwdata);
      tick();
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    chk($sformatf("v%0d stall_cycles", idx), n_stall, v.dly + 1);
    chk($sformatf("v%0d stall_done", idx), stall, 1'b0);
    chk($sformatf("v%0d req_done", idx), mem_req, 1'b0);
    chk($sformatf("v%0d data_valid", idx), data_valid, v.rd && !v.wr);
    if (data_valid) begin
      if (sb_q.size() == 0) begin
        chk($sformatf("v%0d sb_empty", idx), 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d rdata_word", idx), rdata_word, e.rdata);
        chk($sformatf("v%0d addr_low", idx), addr_low, e.alow);
        chk($sformatf("v%0d loadtype_out", idx), loadtype_out, e.lt);
      end
    end
    idle_inputs();
    tick();
    chk($sformatf("v%0d dv_one_cycle", idx), data_valid, 1'b0);
    chk($sformatf("v%0d stall_after", idx), stall, 1'b0);
    chk($sformatf("v%0d req_after", idx), mem_req, 1'b0);
  endtask

  initial begin
    vec_t v;
    //          rd    wr    lt      st       addr          wdata         dly       rdata         err   be       mwdata
    vecs[0]  = '{1'b1, 1'b0, LT_LW,  ST_SB,   32'h0000_0100, 32'h0,        0,        32'hDEADBEEF, 1'b0, 4'b1111, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, LT_LB,  ST_SB,   32'h0000_0203, 32'h0000_00A5, 0,       32'h0,        1'b0, 4'b1000, 32'hA5A5A5A5};
    vecs[2]  = '{1'b1, 1'b0, LT_LH,  ST_SB,   32'h0000_0101, 32'h0,        0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, LT_LBU, ST_SB,   32'h0000_0302, 32'h0,        LONG_DLY, 32'h11223344, 1'b0, 4'b1111, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, LT_LB,  ST_SH,   32'h0000_0102, 32'h1234BEEF, 1,        32'h0,        1'b0, 4'b1100, 32'hBEEFBEEF};
    vecs[5]  = '{1'b0, 1'b1, LT_LB,  ST_SH,   32'h0000_0200, 32'h0000CAFE, 0,        32'h0,        1'b0, 4'b0011, 32'hCAFECAFE};
    vecs[6]  = '{1'b0, 1'b1, LT_LB,  ST_SW,   32'h0000_0002, 32'h1,        0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, LT_LW,  ST_SB,   32'h0000_0106, 32'h0,        0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, LT_LB,  ST_SW,   32'h0000_0040, 32'h87654321, 2,        32'h0,        1'b0, 4'b1111, 32'h87654321};
    vecs[9]  = '{1'b0, 1'b1, LT_LB,  ST_RSVD, 32'h0000_0040, 32'h1,        0,        32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[10] = '{1'b1, 1'b0, LT_LB,  ST_SB,   32'h0000_0007, 32'h0,        2,        32'h80FF00AA, 1'b0, 4'b1111, 32'h0};
    vecs[11] = '{1'b1, 1'b0, LT_LHU, ST_SB,   32'h0000_0012, 32'h0,        0,        32'h0000F00D, 1'b0, 4'b1111, 32'h0};
    vecs[12] = '{1'b1, 1'b1, LT_LW,  ST_SB,   32'h0000_0001, 32'h0000005A, 1,        32'h55555555, 1'b0, 4'b0010, 32'h5A5A5A5A};
    vecs[13] = '{1'b0, 1'b1, LT_LB,  ST_SB,   32'h0000_0000, 32'h000000C3, 0,        32'h0,        1'b0, 4'b0001, 32'hC3C3C3C3};

    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    idle_inputs();
    tick();
    tick();
    chk("rst stall", stall, 1'b0);
    chk("rst mem_req", mem_req, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst mem_be", mem_be, 4'b0000);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst rdata_word", rdata_word, 32'h0);
    chk("rst data_valid", data_valid, 1'b0);
    chk("rst bus_err", bus_err, 1'b0);
    chk("rst addr_low", addr_low, 2'b00);
    chk("rst loadtype_out", loadtype_out, 3'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);
    chk("sb drained", sb_q.size(), 0);

    // ack while idle must not start or complete anything
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    chk("idle_ack req", mem_req, 1'b0);
    chk("idle_ack dv", data_valid, 1'b0);
    chk("idle_ack stall", stall, 1'b0);
    chk("idle_ack rdata", rdata_word, 32'h0000F00D);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    tick();

    // reset while a read is outstanding, ack arrives afterwards
    v = vecs[0];
    v.addr = 32'h0000_0080;
    drive(v);
    tick();
    chk("midrst req_before", mem_req, 1'b1);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("midrst req_drop", mem_req, 1'b0);
    chk("midrst stall", stall, 1'b0);
    chk("midrst mem_addr", mem_addr, 32'h0);
    chk("midrst rdata", rdata_word, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hFEEDFACE;
    tick();
    chk("midrst late_ack dv", data_valid, 1'b0);
    chk("midrst late_ack req", mem_req, 1'b0);
    chk("midrst late_ack stall", stall, 1'b0);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    tick();
    chk("midrst dv_after", data_valid, 1'b0);
    chk("midrst rdata_after", rdata_word, 32'h0);

    // long wait without ack: watchdog fires, or the request just keeps waiting
    v = vecs[0];
    v.addr = 32'h0000_0020;
    drive(v);
    tick();
`ifdef MEM_TIMEOUT_EN
    mem_ack   = 1'b1;
    mem_rdata = 32'hA1B2C3D4;
    tick();
    mem_ack   = 1'b0;
    chk("tmo primed rdata", rdata_word, 32'hA1B2C3D4);
    idle_inputs();
    tick();
    drive(v);
    tick();
    for (int c = 0; c < TMO; c++) begin
      chk($sformatf("tmo stall c%0d", c), stall, 1'b1);
      chk($sformatf("tmo bus_err c%0d", c), bus_err, 1'b0);
      tick();
    end
    chk("tmo bus_err", bus_err, 1'b1);
    chk("tmo rdata_word", rdata_word, 32'h0);
    chk("tmo stall_rel", stall, 1'b0);
    chk("tmo req_drop", mem_req, 1'b0);
    chk("tmo dv", data_valid, 1'b0);
    idle_inputs();
    tick();
    chk("tmo bus_err_pulse", bus_err, 1'b0);
`else
    for (int c = 0; c < 20; c++) tick();
    chk("wait stall", stall, 1'b1);
    chk("wait req", mem_req, 1'b1);
    chk("wait bus_err", bus_err, 1'b0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BADF00D;
    tick();
    mem_ack   = 1'b0;
    chk("wait dv", data_valid, 1'b1);
    chk("wait rdata", rdata_word, 32'h0BADF00D);
    idle_inputs();
    tick();
    chk("wait stall_rel", stall, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
